// File: rtl/muldiv_seq_if.sv
// Issue/result bundle between the instruction controller and the HI/LO multiply/divide unit.
interface muldiv_seq_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, flush,
      input  busy, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, op, a, b, flush,
      output busy, done, div_by_zero, hi, lo
   );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair.
// Define MULDIV_EARLY_OUT_EN to let MUL finish once the remaining multiplier is zero.
module muldiv_seq #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
   input logic         clk,
   input logic         rst_n,
   muldiv_seq_if.slave bus
);

   localparam int unsigned W2 = 2 * WIDTH;

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [W2-1:0]    acc_q;
   logic [W2-1:0]    mcand_q;
   logic [WIDTH-1:0] mplier_q;
   logic             is_div_q;
   logic             neg_res_q;
   logic             neg_rem_q;
   logic             busy_q;
   logic             done_q;
   logic             dbz_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;

   logic [W2-1:0]    mul_sum;
   logic [WIDTH-1:0] mplier_sh;
   logic             mul_last;
   logic             div_last;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   div_diff;
   logic             q_bit;
   logic [W2-1:0]    div_acc;
   logic [W2-1:0]    prod_fix;
   logic [WIDTH-1:0] quot_fix;
   logic [WIDTH-1:0] rem_fix;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_abs;
   logic [WIDTH-1:0] b_abs;

   always_comb begin
      mul_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
      mplier_sh = mplier_q >> 1;
`ifdef MULDIV_EARLY_OUT_EN
      mul_last  = (cnt_q == CNT_W'(1)) || (mplier_sh == '0);
`else
      mul_last  = (cnt_q == CNT_W'(1));
`endif
      div_last  = (cnt_q == CNT_W'(1));

      // Restoring step: shift the next dividend bit into the partial remainder.
      rem_sh   = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
      div_diff = rem_sh - {1'b0, mcand_q[WIDTH-1:0]};
      q_bit    = ~div_diff[WIDTH];
      div_acc  = {(q_bit ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], q_bit};

      prod_fix = neg_res_q ? -acc_q : acc_q;
      quot_fix = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem_fix  = neg_rem_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];

      a_neg = bus.op[0] && bus.a[WIDTH-1];
      b_neg = bus.op[0] && bus.b[WIDTH-1];
      a_abs = a_neg ? -bus.a : bus.a;
      b_abs = b_neg ? -bus.b : bus.b;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dbz_q     <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         done_q <= 1'b0;
         dbz_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.start && !bus.flush) begin
                  case (bus.op)
                     3'b100: begin
                        hi_q   <= bus.a;
                        done_q <= 1'b1;
                     end
                     3'b101: begin
                        lo_q   <= bus.a;
                        done_q <= 1'b1;
                     end
                     3'b000, 3'b001: begin
                        acc_q     <= '0;
                        mcand_q   <= {{WIDTH{1'b0}}, a_abs};
                        mplier_q  <= b_abs;
                        is_div_q  <= 1'b0;
                        neg_res_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        cnt_q     <= CNT_W'(WIDTH);
                        busy_q    <= 1'b1;
                        state_q   <= StMul;
                     end
                     3'b010, 3'b011: begin
                        if (bus.b == '0) begin
                           hi_q   <= bus.a;
                           lo_q   <= '1;
                           dbz_q  <= 1'b1;
                           done_q <= 1'b1;
                        end else begin
                           acc_q     <= {{WIDTH{1'b0}}, a_abs};
                           mcand_q   <= {{WIDTH{1'b0}}, b_abs};
                           mplier_q  <= '0;
                           is_div_q  <= 1'b1;
                           neg_res_q <= a_neg ^ b_neg;
                           neg_rem_q <= a_neg;
                           cnt_q     <= CNT_W'(WIDTH);
                           busy_q    <= 1'b1;
                           state_q   <= StDiv;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            StMul: begin
               if (bus.flush) begin
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end else begin
                  acc_q    <= mul_sum;
                  mcand_q  <= mcand_q << 1;
                  mplier_q <= mplier_sh;
                  cnt_q    <= cnt_q - CNT_W'(1);
                  if (mul_last) state_q <= StFix;
               end
            end
            StDiv: begin
               if (bus.flush) begin
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end else begin
                  acc_q <= div_acc;
                  cnt_q <= cnt_q - CNT_W'(1);
                  if (div_last) state_q <= StFix;
               end
            end
            StFix: begin
               // A flush landing on the commit edge still wins: HI/LO stay untouched.
               if (!bus.flush) begin
                  if (is_div_q) begin
                     hi_q <= rem_fix;
                     lo_q <= quot_fix;
                  end else begin
                     hi_q <= prod_fix[W2-1:WIDTH];
                     lo_q <= prod_fix[WIDTH-1:0];
                  end
                  done_q <= 1'b1;
               end
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;

endmodule
